// File: rtl/cla4_adder.sv
// cla4_adder: two-stage pipelined 4-bit carry-lookahead adder exporting group propagate/generate
module cla4_adder (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out,
   output logic       p_grp,
   output logic       g_grp,
   output logic       out_valid
);
   logic [3:0] p, g;
   logic       c0, v1;
   logic [4:0] c;
   logic       gg;
   always_ff @(posedge clk) begin
      if (rst) begin
         p  <= '0;
         g  <= '0;
         c0 <= 1'b0;
         v1 <= 1'b0;
      end else begin
         p  <= a ^ b;
         g  <= a & b;
         c0 <= c_in;
         v1 <= in_valid;
      end
   end
   // Flat sum-of-products carries: every carry is two gate levels from p/g/c0.
   assign c[0] = c0;
   assign c[1] = g[0] | (p[0] & c0);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign c[4] = gg | (&p & c0);
   always_ff @(posedge clk) begin
      if (rst) begin
         s         <= '0;
         c_out     <= 1'b0;
         p_grp     <= 1'b0;
         g_grp     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         s         <= p ^ c[3:0];
         c_out     <= c[4];
         p_grp     <= &p;
         g_grp     <= gg;
         out_valid <= v1;
      end
   end
endmodule

// File: tb/tb_cla4_adder.sv
// tb_cla4_adder: scoreboarded random/directed/exhaustive check of cla4_adder against plain arithmetic
module tb_cla4_adder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic       c_in = 1'b0;
   logic [3:0] s;
   logic       c_out, p_grp, g_grp, out_valid;
   int total = 0;
   int bad = 0;
   logic [6:0] exp_q[$];

   cla4_adder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
      .s(s), .c_out(c_out), .p_grp(p_grp), .g_grp(g_grp), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Expected {c_out, s, p_grp, g_grp} from integer arithmetic.
   function automatic logic [6:0] model(input int x, input int y, input int ci);
      int sum;
      logic [4:0] t;
      sum = x + y + ci;
      t = sum[4:0];
      return {t[4], t[3:0], ((x ^ y) == 15), (x + y > 15)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, want);
      end
   endtask

   task automatic issue(input int x, input int y, input int ci, input bit v);
      @(posedge clk);
      #1;
      a = x[3:0];
      b = y[3:0];
      c_in = ci[0];
      in_valid = v;
      if (v && !rst) exp_q.push_back(model(x, y, ci));
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) check("unexpected_valid", {25'd0, c_out, s, p_grp, g_grp}, 32'hFFFF);
         else check("result", {25'd0, c_out, s, p_grp, g_grp}, {25'd0, exp_q.pop_front()});
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", {27'd0, out_valid, c_out, p_grp, g_grp, |s}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue(3, 2, 0, 1);
      issue(0, 0, 0, 0);
      issue(0, 0, 0, 0);
      issue(1, 10, 1, 1);
      issue(0, 0, 0, 0);
      issue(0, 0, 0, 0);
      issue(15, 12, 0, 1);
      issue(15, 0, 1, 1);
      issue(15, 15, 1, 1);
      issue(3, 2, 0, 1);
      issue(1, 10, 1, 1);
      issue(15, 12, 0, 1);
      issue(0, 0, 0, 0);
      issue(0, 0, 0, 0);
      issue(0, 0, 0, 0);
      issue(7, 9, 0, 1);
      issue(4, 4, 1, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      a = 4'd9;
      b = 4'd9;
      in_valid = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_cycle1", {30'd0, out_valid, |s}, 32'd0);
      @(negedge clk);
      check("flush_cycle2", {30'd0, out_valid, |s}, 32'd0);
      for (int i = 0; i < 512; i++) issue(i[7:4], i[3:0], i[8], 1);
      for (int i = 0; i < 300; i++)
         issue($urandom_range(15), $urandom_range(15), $urandom_range(1), $urandom_range(3) != 0);
      issue(0, 0, 0, 0);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
